// File: rtl/fir_result_serializer_if.sv
// Handshake bundle between the FIR datapath, the result serializer and the off-chip host.
`default_nettype none

interface fir_result_serializer_if #(
    parameter int IN_W = 20
);
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      out_byte;
    logic            out_valid;
    logic            out_last;
    logic            host_ack;

    modport slave (
        input  in_data, in_valid, host_ack,
        output in_ready, out_byte, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, host_ack,
        input  in_ready, out_byte, out_valid, out_last
    );
endinterface

`default_nettype wire

// File: rtl/fir_result_serializer.sv
// Rounds/saturates FIR results to 16 bits, queues them in a 2-deep FIFO and
// streams each word MSB-first as two bytes over a 4-phase req/ack link.
`default_nettype none

module fir_result_serializer #(
    parameter int IN_W  = 20,
    parameter int SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fir_result_serializer_if.slave   bus,
    output logic                     sat_flag,
    input  logic                     clr_sat
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_WAITLOW = 2'd2
    } state_t;

    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(32767);
    localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-32768);

    // One guard bit keeps the rounding add from overflowing.
    logic signed [IN_W:0] t_ext, t_sum, t_shr;
    logic                 sat_hi, sat_lo, sat_any;
    logic [15:0]          rounded;

    assign t_ext   = {bus.in_data[IN_W-1], bus.in_data};
    assign t_sum   = t_ext + RND;
    assign t_shr   = t_sum >>> SHIFT;
    assign sat_hi  = t_shr > MAXV;
    assign sat_lo  = t_shr < MINV;
    assign sat_any = sat_hi | sat_lo;
    assign rounded = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : t_shr[15:0]);

    logic [15:0] fifo_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q;
    logic        accept, pop;
    logic        sat_q, sat_d;
    logic        ack_meta_q, ack_s_q;

    state_t      state_q, state_d;
    logic        idx_q, idx_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        count_d = count_q;
        if (accept && !pop)
            count_d = count_q + 2'd1;
        else if (!accept && pop)
            count_d = count_q - 2'd1;
    end

    always_comb begin
        sat_d = sat_q;
        if (accept && sat_any)
            sat_d = 1'b1;
        else if (clr_sat)
            sat_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept)
            fifo_q[wr_ptr_q] <= rounded;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        pop         = 1'b0;
        out_byte_d  = out_byte_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != 2'd0) begin
                    pop     = 1'b1;
                    word_d  = fifo_q[rd_ptr_q];
                    idx_d   = 1'b0;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                // Outputs are registered, so request drops on the same edge ack_s is seen.
                out_byte_d  = idx_q ? word_q[7:0] : word_q[15:8];
                out_valid_d = !ack_s_q;
                out_last_d  = !ack_s_q && idx_q;
                if (ack_s_q)
                    state_d = S_WAITLOW;
            end
            S_WAITLOW: begin
                if (!ack_s_q) begin
                    if (!idx_q) begin
                        idx_d   = 1'b1;
                        state_d = S_PRESENT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b0;
            sat_q       <= 1'b0;
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
            state_q     <= S_IDLE;
            idx_q       <= 1'b0;
            word_q      <= 16'h0000;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept)
                wr_ptr_q <= ~wr_ptr_q;
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            count_q     <= count_d;
            in_ready_q  <= (count_d != 2'd2);
            sat_q       <= sat_d;
            ack_meta_q  <= bus.host_ack;
            ack_s_q     <= ack_meta_q;
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign sat_flag      = sat_q;
endmodule

`default_nettype wire

// File: tb/tb_fir_result_serializer.sv
// Directed and host-delay-randomised checks of the FIR result serializer.
`default_nettype none

module tb_fir_result_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_sat = 1'b0;
    logic sat_flag;

    fir_result_serializer_if #(.IN_W(20)) bus ();

    fir_result_serializer #(.IN_W(20), .SHIFT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .sat_flag (sat_flag),
        .clr_sat  (clr_sat)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [19:0] d);
        longint v;
        v = $signed(d);
        v = (v + 8) >>> 4;
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push(input logic [19:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [7:0] exp_b, input logic exp_last, input int delay);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_seen"}, 32'(n < 300), 32'd1);
        check({tag, "_byte"}, bus.out_byte, exp_b);
        check({tag, "_last"}, bus.out_last, exp_last);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({tag, "_held"}, {bus.out_valid, bus.out_byte}, {1'b1, exp_b});
        end
        bus.host_ack = 1'b1;
        n = 0;
        while (bus.out_valid !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_drop"}, 32'(n < 50), 32'd1);
        bus.host_ack = 1'b0;
    endtask

    initial begin
        logic [19:0] d;
        logic [15:0] w;
        int n;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.host_ack = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_byte", bus.out_byte, 8'h00);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_sat_flag", sat_flag, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", bus.in_ready, 1'b1);

        // Basic word and two-edge latency to the first request.
        bus.in_data  = 20'h00123;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("lat_n0", bus.out_valid, 1'b0);
        @(negedge clk);
        check("lat_n1", bus.out_valid, 1'b0);
        @(negedge clk);
        check("lat_n2", bus.out_valid, 1'b1);
        recv("w123_hi", 8'h00, 1'b0, 1);
        recv("w123_lo", 8'h12, 1'b1, 0);
        check("w123_sat", sat_flag, 1'b0);

        // Positive clamp, clear, and set-beats-clear.
        push(20'h7FFFF);
        check("sat_set", sat_flag, 1'b1);
        recv("clamp_hi", 8'h7F, 1'b0, 2);
        recv("clamp_lo", 8'hFF, 1'b1, 0);
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        check("sat_clr", sat_flag, 1'b0);
        clr_sat      = 1'b1;
        bus.in_data  = 20'h7FFFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr_sat      = 1'b0;
        check("sat_set_wins", sat_flag, 1'b1);
        recv("clamp2_hi", 8'h7F, 1'b0, 0);
        recv("clamp2_lo", 8'hFF, 1'b1, 0);
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;

        // Most-negative input lands exactly on -32768 without clamping.
        push(20'h80000);
        recv("neg_hi", 8'h80, 1'b0, 0);
        recv("neg_lo", 8'h00, 1'b1, 0);
        check("neg_sat", sat_flag, 1'b0);
        push(20'hFFFEF);
        recv("m17_hi", 8'hFF, 1'b0, 1);
        recv("m17_lo", 8'hFF, 1'b1, 1);
        push(20'h7FFF0);
        recv("max_hi", 8'h7F, 1'b0, 0);
        recv("max_lo", 8'hFF, 1'b1, 0);
        check("max_sat", sat_flag, 1'b0);

        // Backpressure: host silent while three words arrive back-to-back.
        repeat (4) @(negedge clk);
        check("bp_rdy_before", bus.in_ready, 1'b1);
        push(20'h12340);
        push(20'h05670);
        push(20'h7FFF0);
        check("bp_rdy_full", bus.in_ready, 1'b0);
        repeat (5) @(negedge clk);
        check("bp_rdy_stall", bus.in_ready, 1'b0);
        check("bp_stall_req", {bus.out_valid, bus.out_byte}, {1'b1, 8'h12});
        recv("bp0", 8'h12, 1'b0, 0);
        recv("bp1", 8'h34, 1'b1, 0);
        recv("bp2", 8'h05, 1'b0, 0);
        recv("bp3", 8'h67, 1'b1, 0);
        recv("bp4", 8'h7F, 1'b0, 0);
        recv("bp5", 8'hFF, 1'b1, 0);
        check("bp_rdy_after", bus.in_ready, 1'b1);

        // Random words against the reference model with random host delays.
        for (int k = 0; k < 50; k++) begin
            d = 20'($urandom);
            w = model(d);
            push(d);
            recv("rnd_hi", w[15:8], 1'b0, int'($urandom_range(7, 0)));
            recv("rnd_lo", w[7:0], 1'b1, int'($urandom_range(7, 0)));
        end

        // Asynchronous reset while the LSB byte is being presented.
        repeat (4) @(negedge clk);
        push(20'h7FFFF);
        check("pre_rst_sat", sat_flag, 1'b1);
        recv("ar_hi", 8'h7F, 1'b0, 0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ar_lsb_req", {bus.out_valid, bus.out_last, bus.out_byte}, {1'b1, 1'b1, 8'hFF});
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", bus.out_valid, 1'b0);
        check("ar_out_last", bus.out_last, 1'b0);
        check("ar_out_byte", bus.out_byte, 8'h00);
        check("ar_in_ready", bus.in_ready, 1'b0);
        check("ar_sat", sat_flag, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_rdy_rel", bus.in_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("ar_empty", bus.out_valid, 1'b0);
        push(20'h0ABC0);
        recv("post_hi", 8'h0A, 1'b0, 1);
        recv("post_lo", 8'hBC, 1'b1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fir_result_serializer.md
Name: fir_result_serializer

Overview:
- Output stage directly downstream of the FIR datapath inside tt_um_fir_top.
- Takes wide signed accumulator results over a valid/ready interface.
- Round-shifts and saturates each result to 16 bits, then buffers it in a 2-entry FIFO.
- Streams each word as two bytes, MSB first, over uo_out using a 4-phase req/ack handshake with the off-chip host.

Parameters:
- IN_W, 20, width of signed FIR accumulator input (min 17).
- SHIFT, 4, arithmetic right shift applied with round-half-up (min 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  IN_W  signed FIR result
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word
- out_byte  out  8  byte presented to host (uo_out)
- out_valid  out  1  byte request, 4-phase req
- out_last  out  1  high while presenting the LSB (second) byte
- host_ack  in  1  host acknowledge; asynchronous to clk
- sat_flag  out  1  sticky: some accepted word saturated
- clr_sat  in  1  synchronous clear of sat_flag

Behaviour:
- Reset (async, rst_n=0) clears the following; all take effect immediately on assertion, including mid-transfer:
  - outputs: out_byte=0x00, out_valid=0, out_last=0, in_ready=0, sat_flag=0;
  - FIFO emptied, FSM=IDLE, ack synchronizer=0.
- in_ready:
  - registered; equals FIFO-not-full;
  - first goes 1 on the first clk edge after reset release.
- Accept: in_valid && in_ready at a rising edge.
- Arithmetic, computed at IN_W+1 bits:
  - t = in_data + 2^(SHIFT-1);
  - y = t >>> SHIFT (floor);
  - if y > 32767, store 0x7FFF; if y < -32768, store 0x8000;
  - either clamp sets the word's sat bit.
- FIFO:
  - 2 entries of {16-bit word, sat bit}; write on accept.
  - Write is blocked when full because in_ready=0, so push-when-full cannot occur.
  - Push and pop in the same cycle is legal when the FIFO holds 1 entry; occupancy stays unchanged.
- sat_flag:
  - set on the edge a saturating word is accepted;
  - clr_sat clears it;
  - if set and clear occur in the same cycle, set wins.
- host_ack: passes through a 2-flop synchronizer to give ack_s; only ack_s is used.
- FSM states:
  - IDLE: out_valid=0. If FIFO non-empty: pop the word into the shift register, idx=0, go PRESENT.
  - PRESENT: out_valid=1; out_byte = word[15:8] when idx=0, word[7:0] when idx=1; out_last=(idx==1). When ack_s=1: go WAITLOW, out_valid=0.
  - WAITLOW: out_valid=0; out_byte holds its value. When ack_s=0: if idx==0, set idx=1 and go PRESENT; else go IDLE.
- Latency, empty FIFO: word accepted at edge N, popped at edge N+1, so out_valid=1 from edge N+2.
- out_byte is stable for the whole time out_valid=1.
- If ack_s is already high on entry to PRESENT (host protocol violation), the block completes the transfer immediately. It does not hang.
- Backpressure: a host that never acks stalls the FSM. Once the FIFO fills, in_ready=0 and the FIR stage stalls. No data is dropped.

Test Plan:
- Reset, then push in_data=0x00123 -> bytes 0x00 then 0x12 (out_last=0 then 1); sat_flag=0; out_valid rises 2 clocks after accept.
- Push 0x7FFFF (y=32768) -> bytes 0x7F, 0xFF; sat_flag=1. Then pulse clr_sat -> sat_flag=0. Then clr_sat asserted together with accepting 0x7FFFF -> sat_flag=1.
- Push 0x80000 (-524288, y=-32768, no clamp) -> 0x80, 0x00 with sat_flag=0. Push 0xFFFEF (-17) -> 0xFF, 0xFF.
- Host withholds ack; push 3 words back-to-back -> in_ready drops after the FIFO holds 2 entries plus 1 in the serializer. Release ack -> all 6 bytes arrive in order with none lost.
- Randomized host_ack delays of 0–7 cycles over 50 words -> every byte is held while out_valid=1, and the byte stream matches the reference model.
- Assert rst_n=0 while PRESENT with idx=1 -> outputs reset immediately. After release, FIFO is empty, out_valid=0, and the next pushed word transfers cleanly.
